// File: rtl/multiplier_control.sv
// rtl/multiplier_control.sv - sequencer for the signed shift-add multiplier datapath (X:A:B)
// Optional feature: define MULT_CTRL_HOLD_EN to hold DONE while Run stays high and start on Run level.
module multiplier_control #(
  parameter int N_BITS = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Ld_B,
  output logic Clr_A,
  output logic Clr_X,
  output logic Add,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic start;

`ifdef MULT_CTRL_HOLD_EN
  assign start = Run;
`else
  // Edge-triggered start so a held Run cannot retrigger after DONE.
  logic run_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= Run;
    end
  end

  assign start = Run & ~run_q;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    Ld_B       = 1'b0;
    Clr_A      = 1'b0;
    Clr_X      = 1'b0;
    Add        = 1'b0;
    Sub        = 1'b0;
    Shift_En   = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        Ld_B  = ClearA_LoadB;
        Clr_A = ClearA_LoadB;
        Clr_X = ClearA_LoadB;
        if (start) begin
          state_next = CLR;
        end
      end
      CLR: begin
        Clr_A      = 1'b1;
        Clr_X      = 1'b1;
        Busy       = 1'b1;
        cnt_next   = '0;
        state_next = ADD;
      end
      ADD: begin
        Busy = 1'b1;
        // The sign bit of the multiplier carries negative weight, hence subtract on the last step.
        if (cnt == LAST) begin
          Sub = M;
        end else begin
          Add = M;
        end
        state_next = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
        if (cnt == LAST) begin
          state_next = DONE;
        end else begin
          cnt_next   = cnt + 1'b1;
          state_next = ADD;
        end
      end
      DONE: begin
        Done = 1'b1;
`ifdef MULT_CTRL_HOLD_EN
        if (!Run) begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multiplier_control.sv
// tb/tb_multiplier_control.sv - scoreboard bench for multiplier_control with a behavioural X:A:B datapath
module tb_multiplier_control;

  localparam int N = 8;
`ifdef MULT_CTRL_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Run = 1'b0;
  logic ClearA_LoadB = 1'b0;
  logic M;
  logic Ld_B, Clr_A, Clr_X, Add, Sub, Shift_En, Busy, Done;

  logic [N-1:0] sw_s = '0;
  logic [N-1:0] sw_b = '0;
  logic [N-1:0] ra = '0;
  logic [N-1:0] rb = '0;
  logic rx = 1'b0;
  logic [7:0] outv;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int exp_cyc;
    int prod;
    int add_mask;
    int sub_mask;
  } exp_t;
  exp_t sb[$];

  multiplier_control #(.N_BITS(N)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Run(Run),
    .ClearA_LoadB(ClearA_LoadB),
    .M(M),
    .Ld_B(Ld_B),
    .Clr_A(Clr_A),
    .Clr_X(Clr_X),
    .Add(Add),
    .Sub(Sub),
    .Shift_En(Shift_En),
    .Busy(Busy),
    .Done(Done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  assign M    = rb[0];
  assign outv = {Ld_B, Clr_A, Clr_X, Add, Sub, Shift_En, Busy, Done};

  // Datapath driven only by the controller pins: product ends up in A:B.
  always @(posedge Clk) begin
    if (Ld_B) rb <= sw_b;
    if (Clr_A) ra <= '0;
    if (Clr_X) rx <= 1'b0;
    if (Add) {rx, ra} <= {ra[N-1], ra} + {sw_s[N-1], sw_s};
    if (Sub) {rx, ra} <= {ra[N-1], ra} - {sw_s[N-1], sw_s};
    if (Shift_En) {rx, ra, rb} <= {rx, rx, ra, rb[N-1:1]};
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: accumulates per-run activity, pops the scoreboard on each Done rise.
  int shifts = 0;
  int add_mask = 0;
  int sub_mask = 0;
  int overlap = 0;
  int ldb_busy = 0;
  bit done_prev = 1'b0;
  exp_t e;

  always @(negedge Clk) begin
    if (Reset) begin
      shifts = 0; add_mask = 0; sub_mask = 0; overlap = 0; ldb_busy = 0;
      done_prev = 1'b0;
    end else begin
      if (Add) add_mask = add_mask | (1 << shifts);
      if (Sub) sub_mask = sub_mask | (1 << shifts);
      if (Add && Sub) overlap++;
      if (Ld_B && Busy) ldb_busy++;
      if (Shift_En) shifts++;
      if (Done && !done_prev) begin
        chk("sb_has_entry", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("done_latency", cyc, e.exp_cyc);
          chk("product", int'({ra, rb}), e.prod);
          chk("add_steps", add_mask, e.add_mask);
          chk("sub_steps", sub_mask, e.sub_mask);
          chk("shift_count", shifts, N);
          chk("add_sub_overlap", overlap, 0);
          chk("ldb_while_busy", ldb_busy, 0);
        end
        shifts = 0; add_mask = 0; sub_mask = 0; overlap = 0; ldb_busy = 0;
      end
      done_prev = Done;
    end
  end

  task automatic push_expect(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t x;
    x.exp_cyc  = cyc + 2 * N + 2;
    x.prod     = (int'($signed(a)) * int'($signed(b))) & ((1 << (2 * N)) - 1);
    x.add_mask = int'(b) & ((1 << (N - 1)) - 1);
    x.sub_mask = int'(b) & (1 << (N - 1));
    sb.push_back(x);
  endtask

  task automatic run_one(input logic [N-1:0] a, input logic [N-1:0] b, input int mode);
    step();
    sw_s = a;
    sw_b = b;
    if (mode == 0) begin
      ClearA_LoadB = 1'b1;
      step();
      ClearA_LoadB = 1'b0;
      Run = 1'b1;
      push_expect(a, b);
      step();
      Run = 1'b0;
    end else begin
      ClearA_LoadB = 1'b1;
      Run = 1'b1;
      push_expect(a, b);
      @(negedge Clk);
      chk("run_clb_ldb", int'(Ld_B), 1);
      chk("run_clb_not_busy", int'(Busy), 0);
      step();
      ClearA_LoadB = 1'b0;
      Run = 1'b0;
      @(negedge Clk);
      chk("run_clb_clr_state", int'(outv), 8'b0110_0010);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      ClearA_LoadB = 1'($urandom_range(0, 1));
      Run = (k >= 1 && k < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    step();
    ClearA_LoadB = 1'b0;
    Run = 1'b0;
    for (int t = 0; t < 60 && sb.size() != 0; t++) step();
    chk("run_completed", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
    step();
  endtask

  task automatic reset_mid_shift();
    int n;
    int act_cnt;
    step();
    sw_s = 8'h3c;
    sw_b = 8'hff;
    ClearA_LoadB = 1'b1;
    step();
    ClearA_LoadB = 1'b0;
    Run = 1'b1;
    step();
    Run = 1'b0;
    n = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge Clk);
      if (Shift_En) begin
        n++;
        if (n == 4) break;
      end
    end
    chk("rst_reached_shift3", n, 4);
    Reset = 1'b1;
    #1;
    chk("rst_async_outputs", int'(outv), 0);
    step();
    step();
    Reset = 1'b0;
    act_cnt = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge Clk);
      act_cnt += int'(Busy) + int'(Shift_En) + int'(Done);
    end
    chk("rst_no_further_activity", act_cnt, 0);
  endtask

  task automatic run_held();
    int busy_c, done_c, rises;
    bit prev;
    logic [N-1:0] a, b;
    a = N'($urandom);
    b = N'($urandom);
    step();
    sw_s = a;
    sw_b = b;
    ClearA_LoadB = 1'b1;
    step();
    ClearA_LoadB = 1'b0;
    Run = 1'b1;
    push_expect(a, b);
    busy_c = 0; done_c = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      busy_c += int'(Busy);
      done_c += int'(Done);
      if (Done && !prev) rises++;
      prev = Done;
      step();
    end
    chk("held_busy_cycles", busy_c, 2 * N + 1);
    chk("held_done_cycles", done_c, HOLD ? 40 - (2 * N + 2) : 1);
    chk("held_done_rises", rises, 1);
    Run = 1'b0;
    busy_c = 0; done_c = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      busy_c += int'(Busy);
      done_c += int'(Done);
      step();
    end
    chk("released_busy", busy_c, 0);
    chk("released_done", done_c, HOLD ? 1 : 0);
    chk("held_sb_empty", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge Clk);
    chk("reset_outputs_zero", int'(outv), 0);
    ClearA_LoadB = 1'b1;
    #1;
    chk("reset_idle_clb", int'(outv), 8'b1110_0000);
    ClearA_LoadB = 1'b0;
    step();
    Reset = 1'b0;
    step();
    step();
    ClearA_LoadB = 1'b1;
    @(negedge Clk);
    chk("idle_clb_outputs", int'(outv), 8'b1110_0000);
    step();
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    chk("idle_stays_idle", int'(outv), 0);

    run_one(N'($urandom), 8'h05, 0);
    run_one(N'($urandom), 8'h80, 0);
    run_one(8'h80, 8'h80, 1);
    for (int i = 0; i < 10; i++) run_one(N'($urandom), N'($urandom), int'($urandom_range(0, 1)));
    reset_mid_shift();
    for (int i = 0; i < 10; i++) run_one(N'($urandom), N'($urandom), int'($urandom_range(0, 1)));
    run_held();
    run_one(8'h7f, 8'hff, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
